// File: rtl/init_seq_pkg.sv
// Shared types, widths and the round-robin grant helper for the multi-device init sequencer.
package init_seq_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned DEV_W   = 3;
    localparam int unsigned MAX_DEV = 8;

    typedef enum logic [STATE_W-1:0] {
        S_STARTUP    = 3'd0,
        S_INIT_START = 3'd1,
        S_INIT_WAIT  = 3'd2,
        S_IDLE       = 3'd3,
        S_RD_START   = 3'd4,
        S_RD_WAIT    = 3'd5
    } state_e;

    // First eligible device strictly after 'last', wrapping modulo n_dev; returns 'last' if none.
    function automatic logic [DEV_W-1:0] rr_next_grant(
        input logic [MAX_DEV-1:0] eligible,
        input logic [DEV_W-1:0]   last,
        input int unsigned        n_dev
    );
        logic [DEV_W-1:0] grant;
        logic             found;
        int unsigned      idx;
        grant = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_DEV; i++) begin
            idx = (32'(last) + i) % n_dev;
            if (!found && (i <= n_dev) && eligible[DEV_W'(idx)]) begin
                grant = DEV_W'(idx);
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Free-running divider: one-cycle tick every CLKDIV clocks, phase counted from reset release.
module us_tick_gen #(
    parameter int unsigned CLKDIV = 50
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int unsigned        DIV_W    = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLKDIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    // Wrap the divider and raise the tick for the cycle it sits on its last count
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_d == DIV_LAST);
    end

    // Divider and tick registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/multi_dev_init_seq.sv
// Power-up init sequencer with timeout/retry per device, then round-robin register-read service.
module multi_dev_init_seq
    import init_seq_pkg::*;
#(
    parameter int unsigned N_DEV            = 2,
    parameter int unsigned CLKDIV           = 50,
    parameter int unsigned STARTUP_DELAY_US = 1000000,
    parameter int unsigned INIT_TIMEOUT_US  = 1000000,
    parameter int unsigned READ_TIMEOUT_US  = 600,
    parameter int unsigned MAX_RETRY        = 3,
    parameter int unsigned CNT_W            = 24
) (
    input  logic               clk,
    input  logic               reset,
    output logic [N_DEV-1:0]   init_start,
    input  logic [N_DEV-1:0]   init_done,
    input  logic [N_DEV-1:0]   rd_req,
    output logic [N_DEV-1:0]   rd_start,
    input  logic [N_DEV-1:0]   rd_done,
    output logic               busy,
    output logic               all_init_ok,
    output logic [N_DEV-1:0]   init_fail,
    output logic               rd_timeout,
    output logic [DEV_W-1:0]   cur_dev,
    output logic [STATE_W-1:0] state_dbg
);

    localparam int unsigned      ATT_W       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CNT_W-1:0] STARTUP_CNT = CNT_W'(STARTUP_DELAY_US);
    localparam logic [CNT_W-1:0] INIT_TO_CNT = CNT_W'(INIT_TIMEOUT_US);
    localparam logic [CNT_W-1:0] READ_TO_CNT = CNT_W'(READ_TIMEOUT_US);
    localparam logic [DEV_W-1:0] LAST_DEV    = DEV_W'(N_DEV - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DEV_W-1:0]   cur_dev_q, cur_dev_d;
    logic [DEV_W-1:0]   rr_last_q, rr_last_d;
    logic [ATT_W-1:0]   attempt_q, attempt_d;
    logic [N_DEV-1:0]   init_fail_q, init_fail_d;
    logic [N_DEV-1:0]   init_start_q, init_start_d;
    logic [N_DEV-1:0]   rd_start_q, rd_start_d;
    logic               rd_timeout_q, rd_timeout_d;
    logic               busy_q, busy_d;

    logic               tick;
    logic [MAX_DEV-1:0] init_done_ext, rd_done_ext, eligible_ext;
    logic [MAX_DEV-1:0] cur_onehot, next_onehot;
    logic               cur_init_done, cur_rd_done;

    us_tick_gen #(.CLKDIV(CLKDIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Widen per-device vectors so the current-device index can address them directly
    always_comb begin
        init_done_ext = MAX_DEV'(init_done);
        rd_done_ext   = MAX_DEV'(rd_done);
        eligible_ext  = MAX_DEV'(rd_req & ~init_fail_q);
        cur_onehot    = MAX_DEV'(1) << cur_dev_q;
        cur_init_done = init_done_ext[cur_dev_q];
        cur_rd_done   = rd_done_ext[cur_dev_q];
    end

    // Next-state and bookkeeping; completion always beats a same-cycle timeout
    always_comb begin
        state_d      = state_q;
        cur_dev_d    = cur_dev_q;
        rr_last_d    = rr_last_q;
        attempt_d    = attempt_q;
        init_fail_d  = init_fail_q;
        rd_timeout_d = 1'b0;
        case (state_q)
            S_STARTUP: begin
                if (cnt_q >= STARTUP_CNT) begin
                    state_d   = S_INIT_START;
                    cur_dev_d = '0;
                    attempt_d = '0;
                end
            end
            S_INIT_START: state_d = S_INIT_WAIT;
            S_INIT_WAIT: begin
                if (cur_init_done || (cnt_q >= INIT_TO_CNT)) begin
                    if (!cur_init_done && (attempt_q < ATT_W'(MAX_RETRY))) begin
                        attempt_d = attempt_q + ATT_W'(1);
                        state_d   = S_INIT_START;
                    end else begin
                        if (!cur_init_done) begin
                            init_fail_d = init_fail_q | N_DEV'(cur_onehot);
                        end
                        attempt_d = '0;
                        if (cur_dev_q == LAST_DEV) begin
                            state_d = S_IDLE;
                        end else begin
                            cur_dev_d = cur_dev_q + DEV_W'(1);
                            state_d   = S_INIT_START;
                        end
                    end
                end
            end
            S_IDLE: begin
                if (|eligible_ext) begin
                    cur_dev_d = rr_next_grant(eligible_ext, rr_last_q, N_DEV);
                    rr_last_d = cur_dev_d;
                    state_d   = S_RD_START;
                end
            end
            S_RD_START: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (cur_rd_done) begin
                    state_d = S_IDLE;
                end else if (cnt_q >= READ_TO_CNT) begin
                    state_d      = S_IDLE;
                    rd_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_STARTUP;
                cur_dev_d = '0;
                attempt_d = '0;
            end
        endcase
    end

    // Delay counter (cleared on state entry, saturating) and registered output pulses
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        next_onehot  = MAX_DEV'(1) << cur_dev_d;
        init_start_d = (state_d == S_INIT_START) ? N_DEV'(next_onehot) : '0;
        rd_start_d   = (state_d == S_RD_START)   ? N_DEV'(next_onehot) : '0;
        busy_d       = (state_d != S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_STARTUP;
            cnt_q        <= '0;
            cur_dev_q    <= '0;
            rr_last_q    <= LAST_DEV;
            attempt_q    <= '0;
            init_fail_q  <= '0;
            init_start_q <= '0;
            rd_start_q   <= '0;
            rd_timeout_q <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cur_dev_q    <= cur_dev_d;
            rr_last_q    <= rr_last_d;
            attempt_q    <= attempt_d;
            init_fail_q  <= init_fail_d;
            init_start_q <= init_start_d;
            rd_start_q   <= rd_start_d;
            rd_timeout_q <= rd_timeout_d;
            busy_q       <= busy_d;
        end
    end

    assign init_start  = init_start_q;
    assign rd_start    = rd_start_q;
    assign rd_timeout  = rd_timeout_q;
    assign busy        = busy_q;
    assign init_fail   = init_fail_q;
    assign cur_dev     = cur_dev_q;
    assign state_dbg   = state_q;
    assign all_init_ok = ((state_q == S_IDLE) || (state_q == S_RD_START) || (state_q == S_RD_WAIT))
                         && (init_fail_q == '0);

endmodule

// File: tb/tb_multi_dev_init_seq.sv
// Randomized bench for multi_dev_init_seq against a transaction-level expectation model.
module tb_multi_dev_init_seq;

    localparam int N      = 2;
    localparam int CLKDIV = 4;
    localparam int SU     = 10;
    localparam int ITO    = 20;
    localparam int RTO    = 6;
    localparam int MR     = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] init_start, init_done, rd_req, rd_start, rd_done, init_fail;
    logic         busy, all_init_ok, rd_timeout;
    logic [2:0]   cur_dev, state_dbg;

    int cyc;
    int n_cmp = 0;
    int n_err = 0;
    int n_is  = 0;
    int n_rs  = 0;
    int n_rt  = 0;
    int plan_resp [N];
    int plan_dly  [N];

    multi_dev_init_seq #(
        .N_DEV(N), .CLKDIV(CLKDIV), .STARTUP_DELAY_US(SU), .INIT_TIMEOUT_US(ITO),
        .READ_TIMEOUT_US(RTO), .MAX_RETRY(MR), .CNT_W(24)
    ) dut (
        .clk(clk), .reset(reset), .init_start(init_start), .init_done(init_done),
        .rd_req(rd_req), .rd_start(rd_start), .rd_done(rd_done), .busy(busy),
        .all_init_ok(all_init_ok), .init_fail(init_fail), .rd_timeout(rd_timeout),
        .cur_dev(cur_dev), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Cycles since reset release
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Pulse counters (values seen during the cycle that just ended)
    always @(posedge clk) begin
        if (!reset) begin
            if (init_start != '0) n_is++;
            if (rd_start != '0)   n_rs++;
            if (rd_timeout)       n_rt++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic in_window(input string tag, input int val, input int lo, input int hi);
        chk($sformatf("%s=%0d[%0d..%0d]", tag, val, lo, hi), 32'(val >= lo && val <= hi), 32'(1));
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic do_reset();
        reset     = 1'b1;
        init_done = '0;
        rd_req    = '0;
        rd_done   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_init_pulse(output int t, output logic [N-1:0] v);
        t = -1;
        v = '0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (init_start != '0) begin
                t = cyc;
                v = init_start;
                break;
            end
        end
    endtask

    task automatic power_up(output logic [N-1:0] exp_fail);
        int t, prev_t, snap, total;
        bit first, prev_done;
        logic [N-1:0] v;
        exp_fail  = '0;
        prev_t    = 0;
        first     = 1'b1;
        prev_done = 1'b0;
        total     = 0;
        snap      = n_is;
        for (int d = 0; d < N; d++) begin
            if (plan_resp[d] > MR) exp_fail[d] = 1'b1;
            for (int a = 0; a <= MR; a++) begin
                if (a > plan_resp[d]) break;
                total++;
                wait_init_pulse(t, v);
                chk($sformatf("init_start_d%0d_a%0d", d, a), 32'(v), 32'(oh(d)));
                if (first)          in_window("startup_lat", t - prev_t, SU*CLKDIV - CLKDIV, SU*CLKDIV + CLKDIV);
                else if (prev_done) in_window("done_to_start", t - prev_t, 1, 2);
                else                in_window("retry_gap", t - prev_t, ITO*CLKDIV - CLKDIV, ITO*CLKDIV + CLKDIV);
                first = 1'b0;
                @(negedge clk);
                chk("init_start_width", 32'(init_start), 32'(0));
                chk("busy_in_init", 32'(busy), 32'(1));
                chk("ok_low_in_init", 32'(all_init_ok), 32'(0));
                if (a == plan_resp[d]) begin
                    repeat (plan_dly[d] - 1) @(negedge clk);
                    init_done[d] = 1'b1;
                    prev_t       = cyc;
                    prev_done    = 1'b1;
                end else begin
                    prev_t    = t;
                    prev_done = 1'b0;
                end
            end
        end
        for (int i = 0; i < 150 && busy; i++) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'(0));
        chk("idle_state", 32'(state_dbg), 32'(3));
        chk("init_fail", 32'(init_fail), 32'(exp_fail));
        chk("all_init_ok", 32'(all_init_ok), 32'(exp_fail == '0));
        @(negedge clk);
        chk("init_pulse_count", 32'(n_is - snap), 32'(total));
    endtask

    task automatic reads(input logic [N-1:0] fail, input int n_tr);
        int rr, g, idx, t0, t, dly, snap_rs, snap_rt, exp_rt;
        logic [N-1:0] req, elig, v;
        rr      = N - 1;
        exp_rt  = 0;
        snap_rt = n_rt;
        for (int r = 0; r < n_tr; r++) begin
            req = N'($urandom_range(1, (1 << N) - 1));
            if (r < 3) req = '1;
            if (r == 3 && fail != '0) req = fail;
            elig = req & ~fail;
            for (int i = 0; i < 40 && busy; i++) @(negedge clk);
            chk("rd_idle_busy", 32'(busy), 32'(0));
            if (elig == '0) begin
                snap_rs = n_rs;
                rd_req  = req;
                repeat (10) @(negedge clk);
                chk("masked_no_grant", 32'(n_rs - snap_rs), 32'(0));
                chk("masked_busy", 32'(busy), 32'(0));
                rd_req = '0;
            end else begin
                g = -1;
                for (int i = 1; i <= N; i++) begin
                    idx = (rr + i) % N;
                    if (g < 0 && elig[idx]) g = idx;
                end
                rd_req = req;
                t0     = cyc;
                t      = -1;
                v      = '0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (rd_start != '0) begin
                        t = cyc;
                        v = rd_start;
                        break;
                    end
                end
                rd_req = '0;
                chk($sformatf("rd_grant_req%0b", req), 32'(v), 32'(oh(g)));
                chk("rd_cur_dev", 32'(cur_dev), 32'(g));
                in_window("grant_lat", t - t0, 1, 1);
                chk("ok_in_rd", 32'(all_init_ok), 32'(fail == '0));
                rr = g;
                @(negedge clk);
                chk("rd_start_width", 32'(rd_start), 32'(0));
                if ($urandom_range(0, 1) == 1) begin
                    dly = $urandom_range(1, 14);
                    repeat (dly - 1) @(negedge clk);
                    rd_done = oh(g) | N'($urandom);
                    @(negedge clk);
                    rd_done = '0;
                    chk("rd_done_busy", 32'(busy), 32'(0));
                    chk("rd_done_no_timeout", 32'(rd_timeout), 32'(0));
                end else begin
                    exp_rt++;
                    rd_done = ~oh(g);
                    @(negedge clk);
                    rd_done = '0;
                    chk("other_done_ignored", 32'(busy), 32'(1));
                    t0 = -1;
                    for (int i = 0; i < 40; i++) begin
                        @(negedge clk);
                        if (rd_timeout) begin
                            t0 = cyc;
                            break;
                        end
                    end
                    in_window("rd_timeout_lat", t0 - t, RTO*CLKDIV - CLKDIV, RTO*CLKDIV + CLKDIV);
                    chk("rd_timeout_busy", 32'(busy), 32'(0));
                    @(negedge clk);
                    chk("rd_timeout_width", 32'(rd_timeout), 32'(0));
                end
            end
        end
        @(negedge clk);
        chk("rd_timeout_count", 32'(n_rt - snap_rt), 32'(exp_rt));
    endtask

    task automatic tie_and_reset();
        int t, t0, tr;
        logic [N-1:0] v;
        // Run 1: both devices silent; learn when device 0's first timeout fires
        do_reset();
        wait_init_pulse(t0, v);
        chk("c_first", 32'(v), 32'(oh(0)));
        wait_init_pulse(tr, v);
        chk("c_retry", 32'(v), 32'(oh(0)));
        wait_init_pulse(t, v);
        chk("c_retry2", 32'(v), 32'(oh(0)));
        wait_init_pulse(t, v);
        chk("c_dev1", 32'(v), 32'(oh(1)));
        repeat (5) @(negedge clk);
        chk("pre_reset_state", 32'(state_dbg), 32'(2));
        chk("pre_reset_cur_dev", 32'(cur_dev), 32'(1));
        chk("pre_reset_fail", 32'(init_fail), 32'(oh(0)));
        reset = 1'b1;
        #1;
        chk("async_state", 32'(state_dbg), 32'(0));
        chk("async_cur_dev", 32'(cur_dev), 32'(0));
        chk("async_fail", 32'(init_fail), 32'(0));
        chk("async_busy", 32'(busy), 32'(1));
        chk("async_ok", 32'(all_init_ok), 32'(0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        // Run 2: identical history, device 0 answers exactly on its timeout cycle
        wait_init_pulse(t, v);
        chk("restart_first", 32'(v), 32'(oh(0)));
        in_window("restart_lat", t, SU*CLKDIV - CLKDIV, SU*CLKDIV + CLKDIV);
        for (int i = 0; i < 200 && cyc < tr - 1; i++) @(negedge clk);
        init_done[0] = 1'b1;
        @(negedge clk);
        chk("tie_advances_to_dev1", 32'(init_start), 32'(oh(1)));
        chk("tie_no_fail", 32'(init_fail), 32'(0));
        init_done[1] = 1'b1;
        for (int i = 0; i < 150 && busy; i++) @(negedge clk);
        chk("tie_idle_busy", 32'(busy), 32'(0));
        chk("tie_all_ok", 32'(all_init_ok), 32'(1));
    endtask

    initial begin
        logic [N-1:0] fail;
        reset     = 1'b1;
        init_done = '0;
        rd_req    = '0;
        rd_done   = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(1));
        chk("rst_state", 32'(state_dbg), 32'(0));
        chk("rst_init_start", 32'(init_start), 32'(0));
        chk("rst_rd_start", 32'(rd_start), 32'(0));
        chk("rst_fail", 32'(init_fail), 32'(0));
        chk("rst_ok", 32'(all_init_ok), 32'(0));
        chk("rst_cur_dev", 32'(cur_dev), 32'(0));
        chk("rst_rd_timeout", 32'(rd_timeout), 32'(0));

        for (int it = 0; it < 5; it++) begin
            for (int d = 0; d < N; d++) begin
                plan_resp[d] = $urandom_range(0, MR + 1);
                plan_dly[d]  = $urandom_range(1, 60);
            end
            if (it == 0) begin
                plan_resp[0] = 0; plan_resp[1] = 0;
                plan_dly[0]  = 5; plan_dly[1]  = 5;
            end else if (it == 1) begin
                plan_resp[0] = 0; plan_resp[1] = MR + 1;
            end
            do_reset();
            power_up(fail);
            reads(fail, 8);
        end

        tie_and_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
